// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the March-test BIST controller.
package mem_bist_pkg;
  localparam int         DEF_ADDR_W  = 4;
  localparam int         DEF_DATA_W  = 8;
  localparam logic [7:0] DEF_PATTERN = 8'h55;

  // March element walking direction
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_C, M1_W, M2_R, M2_C, M2_W, M3_R, M3_C, DONE
  } state_t;
endpackage

// File: rtl/mem_bist_addr_ctr.sv
// Up/down address counter; direction is latched on load so the last flag
// depends only on registered state.
module mem_bist_addr_ctr import mem_bist_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_dir,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] TOP = '1;

  logic dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      dir  <= DIR_UP;
    end else if (load) begin
      addr <= (load_dir == DIR_DN) ? TOP : '0;
      dir  <= load_dir;
    end else if (en) begin
      addr <= (dir == DIR_DN) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = (dir == DIR_DN) ? (addr == '0) : (addr == TOP);
endmodule

// File: rtl/mem_bist_ctrl.sv
// March test initiator (w P; r P,w ~P up; r ~P,w P down; r P down) for a
// one-cycle-latency memory, aborting on the first mismatch.
module mem_bist_ctrl import mem_bist_pkg::*; #(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  state_t            state, nxt;
  logic              go, miss, ld, ld_dir, step, last, rd_bad;
  logic [DATA_W-1:0] expect_data;

  mem_bist_addr_ctr #(.ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_dir (ld_dir),
    .en       (step),
    .addr     (mem_addr),
    .last     (last)
  );

  assign expect_data = (state == M2_C) ? ~PATTERN : PATTERN;
  assign rd_bad      = (mem_rdata != expect_data);

  always_comb begin
    nxt    = state;
    go     = 1'b0;
    miss   = 1'b0;
    ld     = 1'b0;
    ld_dir = DIR_UP;
    step   = 1'b0;
    if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nxt = M0_W;
            go  = 1'b1;
            ld  = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
        M0_W: begin
          if (last) begin nxt = M1_R; ld = 1'b1; end
          else step = 1'b1;
        end
        M1_R: nxt = M1_C;
        M1_C: begin
          if (rd_bad) begin miss = 1'b1; nxt = DONE; end
          else nxt = M1_W;
        end
        M1_W: begin
          if (last) begin nxt = M2_R; ld = 1'b1; ld_dir = DIR_DN; end
          else begin nxt = M1_R; step = 1'b1; end
        end
        M2_R: nxt = M2_C;
        M2_C: begin
          if (rd_bad) begin miss = 1'b1; nxt = DONE; end
          else nxt = M2_W;
        end
        M2_W: begin
          if (last) begin nxt = M3_R; ld = 1'b1; ld_dir = DIR_DN; end
          else begin nxt = M2_R; step = 1'b1; end
        end
        M3_R: nxt = M3_C;
        M3_C: begin
          if (rd_bad) begin miss = 1'b1; nxt = DONE; end
          else if (last) nxt = DONE;
          else begin nxt = M3_R; step = 1'b1; end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        pass      <= 1'b1;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (miss) begin
        pass      <= 1'b0;
        fail_addr <= mem_addr;
        fail_data <= mem_rdata;
      end
    end
  end

  // Strobes come from the registered state only; ena just masks them.
  assign busy   = !(state inside {IDLE, DONE});
  assign done   = (state == DONE);
  assign mem_re = ena && (state inside {M1_R, M2_R, M3_R});
  assign mem_we = ena && (state inside {M0_W, M1_W, M2_W});

  always_comb begin
    mem_wdata = '0;
    case (state)
      M0_W, M2_W: mem_wdata = PATTERN;
      M1_W:       mem_wdata = ~PATTERN;
      default:    mem_wdata = '0;
    endcase
  end
endmodule
